spu_mamulred: RTL and testbench

- Responder side of the MA-unit mul/red start/done handshake.
- Accepts one-cycle start pulses (A==B square, or A!=B multiply) from the exponentiation and other MA op controllers.
- Sequences operand-word reads, multiply issue, pipeline drain, reduction issue and result write-back over the MA memory.
- Returns a one-cycle red_done pulse to the requester.

---
 rtl/spu_ma_pkg.sv | 24 ++
 rtl/spu_mamulred_idxcnt.sv | 39 +++
 rtl/spu_mamulred.sv | 199 +++++++++++++++++++
 tb/tb_spu_mamulred.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/spu_ma_pkg.sv
// Shared constants for the MA-unit mul/red sequencer: one-hot state encoding,
// default operand-length width and the drain-latency bound.
package spu_ma_pkg;

  localparam int unsigned ST_W   = 6;
  localparam int unsigned S_IDLE = 0;
  localparam int unsigned S_MUL  = 1;
  localparam int unsigned S_DRN  = 2;
  localparam int unsigned S_RED  = 3;
  localparam int unsigned S_WR   = 4;
  localparam int unsigned S_DONE = 5;

  localparam logic [ST_W-1:0] ST_IDLE = 6'b000001;
  localparam logic [ST_W-1:0] ST_MUL  = 6'b000010;
  localparam logic [ST_W-1:0] ST_DRN  = 6'b000100;
  localparam logic [ST_W-1:0] ST_RED  = 6'b001000;
  localparam logic [ST_W-1:0] ST_WR   = 6'b010000;
  localparam logic [ST_W-1:0] ST_DONE = 6'b100000;

  localparam int unsigned LEN_W_DEF   = 6;
  localparam int unsigned MUL_LAT_MAX = 15;
  localparam int unsigned DRN_W       = $clog2(MUL_LAT_MAX + 1);

endpackage

// File: rtl/spu_mamulred_idxcnt.sv
// Operand word index counter shared by the MUL, RED and WR passes.
// Terminal flag compares against the latched length, so the index never wraps.
module spu_mamulred_idxcnt
  import spu_ma_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic             rclk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [LEN_W-1:0] len_i,
  output logic [LEN_W-1:0] idx_nxt_o,
  output logic             term_o
);

  logic [LEN_W-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (inc_i) begin
      idx_d = idx_q + LEN_W'(1);
    end
  end

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_nxt_o = idx_d;
  assign term_o    = (idx_q == len_i);

endmodule

// File: rtl/spu_mamulred.sv
// MA-unit mul/red responder: sequences operand reads, multiply, drain, reduce and
// write-back, then pulses red_done. Optional busy-cycle counter: SPU_MAMULRED_PERF_CNT_EN.
module spu_mamulred
  import spu_ma_pkg::*;
#(
  parameter int unsigned LEN_W   = LEN_W_DEF,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic             rclk,
  input  logic             reset,
  input  logic             se,
  input  logic             spu_mamulred_start_aequb,
  input  logic             spu_mamulred_start_anoteqb,
  input  logic [LEN_W-1:0] spu_mactl_len,
  input  logic             spu_mactl_kill_op,
  input  logic             spu_mactl_stxa_force_abort,
  output logic             spu_mared_red_done,
  output logic             spu_mamulred_busy,
  output logic             spu_mamulred_memren,
  output logic             spu_mamulred_rd_b_sel,
  output logic             spu_mamulred_mem_wen,
  output logic [LEN_W-1:0] spu_mamulred_word_idx,
  output logic             spu_mamulred_mul_issue,
  output logic             spu_mamulred_red_issue
`ifdef SPU_MAMULRED_PERF_CNT_EN
  ,
  output logic [15:0]      spu_mamulred_cyc_cnt
`endif
);

  logic [ST_W-1:0]  state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             aeqb_q, aeqb_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic             idx_clr, idx_inc, idx_term;
  logic [LEN_W-1:0] idx_nxt;
  logic             start, abort, pass_d;

  logic             red_done_q, busy_q, memren_q, rd_b_sel_q;
  logic             mem_wen_q, mul_issue_q, red_issue_q;
  logic [LEN_W-1:0] word_idx_q;

  // Scan enable has no functional role in this block.
  logic unused_se;
  assign unused_se = se;

  assign start = spu_mamulred_start_aequb | spu_mamulred_start_anoteqb;
  assign abort = spu_mactl_kill_op | spu_mactl_stxa_force_abort;

  spu_mamulred_idxcnt #(.LEN_W(LEN_W)) u_idxcnt (
    .rclk      (rclk),
    .reset     (reset),
    .clr_i     (idx_clr),
    .inc_i     (idx_inc),
    .len_i     (len_q),
    .idx_nxt_o (idx_nxt),
    .term_o    (idx_term)
  );

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      aeqb_q  <= 1'b0;
      drn_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      aeqb_q  <= aeqb_d;
      drn_q   <= drn_d;
    end
  end

  // Next-state: starts only accepted in IDLE; abort overrides every busy state.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    aeqb_d  = aeqb_q;
    drn_d   = drn_q;
    idx_clr = 1'b0;
    idx_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_MUL;
          len_d   = spu_mactl_len;
          aeqb_d  = spu_mamulred_start_aequb;
          idx_clr = 1'b1;
        end
      end
      ST_MUL: begin
        if (idx_term) begin
          state_d = ST_DRN;
          idx_clr = 1'b1;
          drn_d   = DRN_W'(1);
        end else begin
          idx_inc = 1'b1;
        end
      end
      ST_DRN: begin
        if (drn_q == DRN_W'(MUL_LAT)) begin
          state_d = ST_RED;
          drn_d   = '0;
        end else begin
          drn_d = drn_q + DRN_W'(1);
        end
      end
      ST_RED: begin
        if (idx_term) begin
          state_d = ST_WR;
          idx_clr = 1'b1;
        end else begin
          idx_inc = 1'b1;
        end
      end
      ST_WR: begin
        if (idx_term) begin
          state_d = ST_DONE;
          idx_clr = 1'b1;
        end else begin
          idx_inc = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        idx_clr = 1'b1;
        drn_d   = '0;
      end
    endcase
    if (abort && !state_q[S_IDLE]) begin
      state_d = ST_IDLE;
      idx_clr = 1'b1;
      idx_inc = 1'b0;
      drn_d   = '0;
    end
  end

  assign pass_d = state_d[S_MUL] | state_d[S_RED] | state_d[S_WR];

  // Outputs are flops loaded from the next state so they line up with the state register.
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      red_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      memren_q    <= 1'b0;
      rd_b_sel_q  <= 1'b0;
      mem_wen_q   <= 1'b0;
      mul_issue_q <= 1'b0;
      red_issue_q <= 1'b0;
      word_idx_q  <= '0;
    end else begin
      red_done_q  <= state_d[S_DONE];
      busy_q      <= !state_d[S_IDLE];
      memren_q    <= state_d[S_MUL] | state_d[S_RED];
      rd_b_sel_q  <= state_d[S_MUL] & ~aeqb_d;
      mem_wen_q   <= state_d[S_WR];
      mul_issue_q <= state_d[S_MUL];
      red_issue_q <= state_d[S_RED];
      word_idx_q  <= pass_d ? idx_nxt : '0;
    end
  end

  assign spu_mared_red_done     = red_done_q;
  assign spu_mamulred_busy      = busy_q;
  assign spu_mamulred_memren    = memren_q;
  assign spu_mamulred_rd_b_sel  = rd_b_sel_q;
  assign spu_mamulred_mem_wen   = mem_wen_q;
  assign spu_mamulred_word_idx  = word_idx_q;
  assign spu_mamulred_mul_issue = mul_issue_q;
  assign spu_mamulred_red_issue = red_issue_q;

`ifdef SPU_MAMULRED_PERF_CNT_EN
  logic [15:0] cyc_q, cyc_d;

  // Counts working cycles of the last op; the DONE cycle shows the final total.
  always_comb begin
    cyc_d = cyc_q;
    if (state_q[S_IDLE]) begin
      if (start) begin
        cyc_d = '0;
      end
    end else if (!state_q[S_DONE] && (cyc_q != 16'hFFFF)) begin
      cyc_d = cyc_q + 16'd1;
    end
  end

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign spu_mamulred_cyc_cnt = cyc_q;
`endif

endmodule

// File: tb/tb_spu_mamulred.sv
// Self-checking bench for spu_mamulred: per-cycle expected output vectors are
// queued from the documented timeline when an op is started and compared cycle by cycle.
module tb_spu_mamulred;

  localparam int unsigned LW = 6;
  localparam int M = 4;

  logic          rclk = 1'b0;
  logic          reset, se, sa, sn, kill, stxa;
  logic [LW-1:0] len;
  logic          red_done, busy, memren, rd_b_sel, mem_wen, mul_issue, red_issue;
  logic [LW-1:0] word_idx;
`ifdef SPU_MAMULRED_PERF_CNT_EN
  logic [15:0]   cyc_cnt;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [12:0] sb[$];
  logic [12:0] obs, exp_v;

  always #5 rclk = ~rclk;

  spu_mamulred #(.LEN_W(LW), .MUL_LAT(M)) dut (
    .rclk                       (rclk),
    .reset                      (reset),
    .se                         (se),
    .spu_mamulred_start_aequb   (sa),
    .spu_mamulred_start_anoteqb (sn),
    .spu_mactl_len              (len),
    .spu_mactl_kill_op          (kill),
    .spu_mactl_stxa_force_abort (stxa),
    .spu_mared_red_done         (red_done),
    .spu_mamulred_busy          (busy),
    .spu_mamulred_memren        (memren),
    .spu_mamulred_rd_b_sel      (rd_b_sel),
    .spu_mamulred_mem_wen       (mem_wen),
    .spu_mamulred_word_idx      (word_idx),
    .spu_mamulred_mul_issue     (mul_issue),
    .spu_mamulred_red_issue     (red_issue)
`ifdef SPU_MAMULRED_PERF_CNT_EN
    ,
    .spu_mamulred_cyc_cnt       (cyc_cnt)
`endif
  );

  function automatic logic [12:0] obs_vec();
    return {busy, memren, rd_b_sel, mem_wen, mul_issue, red_issue, red_done, word_idx};
  endfunction

  // Expected outputs in cycle c of an op of L words started in cycle 0; abort in cycle ab (-1: none).
  function automatic logic [12:0] exp_vec(input int c, input int L, input logic aeqb, input int ab);
    logic [12:0] v;
    v = '0;
    if (ab >= 0 && c > ab) return v;
    if (c >= 1 && c <= L) begin
      v[12] = 1'b1; v[11] = 1'b1; v[10] = ~aeqb; v[8] = 1'b1; v[5:0] = LW'(c - 1);
    end else if (c > L && c <= L + M) begin
      v[12] = 1'b1;
    end else if (c > L + M && c <= 2*L + M) begin
      v[12] = 1'b1; v[11] = 1'b1; v[7] = 1'b1; v[5:0] = LW'(c - L - M - 1);
    end else if (c > 2*L + M && c <= 3*L + M) begin
      v[12] = 1'b1; v[9] = 1'b1; v[5:0] = LW'(c - 2*L - M - 1);
    end else if (c == 3*L + M + 1) begin
      v[12] = 1'b1; v[6] = 1'b1;
    end
    return v;
  endfunction

  task automatic push_op(input int L, input logic aeqb, input int ab, input int n);
    for (int c = 0; c < n; c++) sb.push_back(exp_vec(c, L, aeqb, ab));
  endtask

  task automatic test_reset();
    @(posedge rclk); #1;
    checks++;
    if (obs_vec() !== 13'd0) begin
      errors++; $display("FAIL reset_state got=%h exp=%h", obs_vec(), 13'd0);
    end
`ifdef SPU_MAMULRED_PERF_CNT_EN
    checks++;
    if (cyc_cnt !== 16'd0) begin errors++; $display("FAIL reset_cyc_cnt got=%0d exp=0", cyc_cnt); end
`endif
    reset = 1'b0;
    push_op(8, 1'b0, -1, 4);
    for (int c = 0; c < 4; c++) begin
      @(posedge rclk); #1;
      obs = obs_vec(); exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL reset_pre cyc=%0d got=%h exp=%h", c, obs, exp_v); end
      sn  = (c == 0);
      len = (c == 0) ? LW'(7) : LW'($urandom);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs_vec() !== 13'd0) begin
      errors++; $display("FAIL reset_mid_mul got=%h exp=%h", obs_vec(), 13'd0);
    end
    #2 reset = 1'b0;
  endtask

  task automatic test_mul_anoteqb();
    int n = 3*4 + M + 4;
    push_op(4, 1'b0, -1, n);
    for (int c = 0; c < n; c++) begin
      @(posedge rclk); #1;
      obs = obs_vec(); exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL anoteqb_len3 cyc=%0d got=%h exp=%h", c, obs, exp_v); end
      sn  = (c == 0);
      len = (c == 0) ? LW'(3) : LW'($urandom);
    end
`ifdef SPU_MAMULRED_PERF_CNT_EN
    checks++;
    if (cyc_cnt !== 16'd16) begin errors++; $display("FAIL cyc_cnt_len3 got=%0d exp=16", cyc_cnt); end
`endif
  endtask

  task automatic test_sq_len0();
    int n = 3*1 + M + 4;
    push_op(1, 1'b1, -1, n);
    for (int c = 0; c < n; c++) begin
      @(posedge rclk); #1;
      obs = obs_vec(); exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL aequb_len0 cyc=%0d got=%h exp=%h", c, obs, exp_v); end
      sa   = (c == 0);
      kill = (c == 0);
      len  = '0;
    end
  endtask

  task automatic test_back_to_back();
    int n = 3*2 + M + 8;
    int dones = 0;
    push_op(2, 1'b1, -1, n);
    for (int c = 0; c < n; c++) begin
      @(posedge rclk); #1;
      obs = obs_vec(); exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL both_starts cyc=%0d got=%h exp=%h", c, obs, exp_v); end
      if (red_done) dones++;
      sa  = (c == 0);
      sn  = (c == 0) || (c == 7);
      len = (c == 0) ? LW'(1) : LW'(5);
    end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL both_starts_done_count got=%0d exp=1", dones); end
  endtask

  task automatic test_kill();
    int n = 20;
    int wens = 0;
    push_op(4, 1'b0, 10, n);
    for (int c = 0; c < n; c++) begin
      @(posedge rclk); #1;
      obs = obs_vec(); exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL kill_red cyc=%0d got=%h exp=%h", c, obs, exp_v); end
      if (mem_wen) wens++;
      sn   = (c == 0);
      kill = (c == 10);
      len  = LW'(3);
    end
    checks++;
    if (wens != 0) begin errors++; $display("FAIL kill_mem_wen got=%0d exp=0", wens); end
  endtask

  task automatic test_abort_done();
    int n = 3*2 + M + 5;
    int dones = 0;
    push_op(2, 1'b0, 11, n);
    for (int c = 0; c < n; c++) begin
      @(posedge rclk); #1;
      obs = obs_vec(); exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL abort_done cyc=%0d got=%h exp=%h", c, obs, exp_v); end
      if (red_done) dones++;
      sn   = (c == 0);
      stxa = (c == 11);
      len  = LW'(1);
    end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL abort_done_count got=%0d exp=1", dones); end
  endtask

  task automatic test_len_max();
    int n = 3*64 + M + 3;
    int muls = 0;
    int max_idx = 0;
    push_op(64, 1'b0, -1, n);
    for (int c = 0; c < n; c++) begin
      @(posedge rclk); #1;
      obs = obs_vec(); exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL len_max cyc=%0d got=%h exp=%h", c, obs, exp_v); end
      if (mul_issue) muls++;
      if (int'(word_idx) > max_idx) max_idx = int'(word_idx);
      sn  = (c == 0);
      len = (c == 0) ? '1 : LW'($urandom);
    end
    checks++;
    if (muls != 64) begin errors++; $display("FAIL len_max_mul_count got=%0d exp=64", muls); end
    checks++;
    if (max_idx != 63) begin errors++; $display("FAIL len_max_idx got=%0d exp=63", max_idx); end
  endtask

  initial begin
    reset = 1'b1; se = 1'b0; sa = 1'b0; sn = 1'b0; kill = 1'b0; stxa = 1'b0; len = '0;
    test_reset();
    test_mul_anoteqb();
    test_sq_len0();
    test_back_to_back();
    test_kill();
    test_abort_done();
    test_len_max();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
